risc_sequencer: RTL and testbench

Parametrised fetch/execute sequencer for the VeriRISC CPU: next generation of the phase-driven controller. It owns its own 8-phase counter rather than taking `phase` from outside. It adds memory wait-state handshaking, a bus-timeout watchdog, a global run enable and a resumable halt state. It sits between the instruction register, accumulator zero flag and memory, and drives the same nine control strobes to the datapath.

---
 rtl/risc_sequencer_if.sv | 32 +++
 rtl/risc_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_risc_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/risc_sequencer_if.sv
// Handshake bundle between the VeriRISC sequencer and its datapath/memory:
// inputs from the IR, accumulator and memory, plus the nine control strobes.
interface risc_sequencer_if #(
    parameter int OP_CODE_WIDTH = 3
);
    logic                     enable;
    logic [OP_CODE_WIDTH-1:0] opcode;
    logic                     zero;
    logic                     mem_ready;
    logic                     resume;
    logic [2:0]               phase;
    logic                     sel;
    logic                     rd;
    logic                     ld_ir;
    logic                     halt;
    logic                     inc_pc;
    logic                     ld_ac;
    logic                     ld_pc;
    logic                     wr;
    logic                     data_e;
    logic                     bus_err;

    modport master (
        input  enable, opcode, zero, mem_ready, resume,
        output phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, bus_err
    );

    modport slave (
        output enable, opcode, zero, mem_ready, resume,
        input  phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, bus_err
    );
endinterface

// File: rtl/risc_sequencer.sv
// VeriRISC fetch/execute sequencer: owns the 8-phase counter, stalls on memory
// wait states, halts on HLT or bus timeout, and decodes the datapath strobes.
module risc_sequencer #(
    parameter int OP_CODE_WIDTH = 3,
    parameter int MAX_WAIT      = 15
) (
    input  logic             clk,
    input  logic             rst,
    risc_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } run_e;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    phase_e     phase_q;
    run_e       run_q;
    logic [7:0] wait_q;
    logic       bus_err_q;

    logic [OP_CODE_WIDTH-1:0] op_hi_s;
    logic                     op_in_range_s;
    logic [2:0]               op_low_s;
    logic                     is_hlt_s;
    logic                     is_skz_s;
    logic                     is_sto_s;
    logic                     is_jmp_s;
    logic                     is_aluop_s;
    logic                     stall_s;

    logic sel_s;
    logic rd_s;
    logic ld_ir_s;
    logic halt_s;
    logic inc_pc_s;
    logic ld_ac_s;
    logic ld_pc_s;
    logic wr_s;
    logic data_e_s;

    // Opcodes are compared zero-extended: any set bit above bit 2 makes it a NOP.
    assign op_hi_s       = bus.opcode >> 3'd3;
    assign op_in_range_s = (op_hi_s == {OP_CODE_WIDTH{1'b0}});
    assign op_low_s      = bus.opcode[2:0];

    assign is_hlt_s   = op_in_range_s && (op_low_s == OP_HLT);
    assign is_skz_s   = op_in_range_s && (op_low_s == OP_SKZ);
    assign is_sto_s   = op_in_range_s && (op_low_s == OP_STO);
    assign is_jmp_s   = op_in_range_s && (op_low_s == OP_JMP);
    assign is_aluop_s = op_in_range_s && ((op_low_s == OP_ADD) || (op_low_s == OP_AND) ||
                                          (op_low_s == OP_XOR) || (op_low_s == OP_LDA));

    assign stall_s = (run_q == RUN) && !bus.mem_ready &&
                     ((phase_q == PH_INST_FETCH) || ((phase_q == PH_OP_FETCH) && is_aluop_s));

    // Phase, run state, wait-state watchdog and sticky bus error.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_INST_ADDR;
            run_q     <= RUN;
            wait_q    <= 8'd0;
            bus_err_q <= 1'b0;
        end else if (bus.enable) begin
            case (run_q)
                RUN: begin
                    if (stall_s) begin
                        // Timeout freezes the phase so the failing access is visible.
                        if (wait_q == WAIT_LIMIT) begin
                            bus_err_q <= 1'b1;
                            run_q     <= HALTED;
                        end else begin
                            wait_q <= wait_q + 8'd1;
                        end
                    end else begin
                        wait_q <= 8'd0;
                        if ((phase_q == PH_OP_ADDR) && is_hlt_s) begin
                            run_q <= HALTED;
                        end else begin
                            phase_q <= phase_e'(phase_q + 3'd1);
                        end
                    end
                end
                HALTED: begin
                    wait_q <= 8'd0;
                    if (bus.resume && !bus_err_q) begin
                        run_q   <= RUN;
                        phase_q <= PH_OP_FETCH;
                    end
                end
                default: begin
                    run_q <= HALTED;
                end
            endcase
        end
    end

    // Strobe decode from the held phase/run state and the live opcode and zero flag.
    always_comb begin
        sel_s    = 1'b0;
        rd_s     = 1'b0;
        ld_ir_s  = 1'b0;
        halt_s   = 1'b0;
        inc_pc_s = 1'b0;
        ld_ac_s  = 1'b0;
        ld_pc_s  = 1'b0;
        wr_s     = 1'b0;
        data_e_s = 1'b0;
        if (run_q == HALTED) begin
            halt_s = 1'b1;
        end else begin
            case (phase_q)
                PH_INST_ADDR: begin
                    sel_s = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel_s = 1'b1;
                    rd_s  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel_s   = 1'b1;
                    rd_s    = 1'b1;
                    ld_ir_s = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc_s = 1'b1;
                    halt_s   = is_hlt_s;
                end
                PH_OP_FETCH: begin
                    rd_s = is_aluop_s;
                end
                PH_ALU_OP: begin
                    rd_s     = is_aluop_s;
                    inc_pc_s = is_skz_s && bus.zero;
                    ld_pc_s  = is_jmp_s;
                    data_e_s = is_sto_s;
                end
                PH_STORE: begin
                    rd_s     = is_aluop_s;
                    ld_ac_s  = is_aluop_s;
                    ld_pc_s  = is_jmp_s;
                    wr_s     = is_sto_s;
                    data_e_s = is_sto_s;
                end
                default: begin
                    sel_s = 1'b0;
                end
            endcase
        end
    end

    assign bus.phase   = phase_q;
    assign bus.sel     = sel_s;
    assign bus.rd      = rd_s;
    assign bus.ld_ir   = ld_ir_s;
    assign bus.halt    = halt_s;
    assign bus.inc_pc  = inc_pc_s;
    assign bus.ld_ac   = ld_ac_s;
    assign bus.ld_pc   = ld_pc_s;
    assign bus.wr      = wr_s;
    assign bus.data_e  = data_e_s;
    assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_risc_sequencer.sv
// Scoreboard bench for risc_sequencer: directed per-cycle vectors with
// hand-written expected phase/strobe/error values, checked by a separate monitor.
module tb_risc_sequencer;

    logic clk;
    logic rst;

    risc_sequencer_if #(.OP_CODE_WIDTH(4)) bus ();

    risc_sequencer #(.OP_CODE_WIDTH(4), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe order: {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}
    localparam logic [8:0] Z    = 9'b000000000;
    localparam logic [8:0] SEL  = 9'b100000000;
    localparam logic [8:0] SR   = 9'b110000000;
    localparam logic [8:0] SRL  = 9'b111000000;
    localparam logic [8:0] INC  = 9'b000010000;
    localparam logic [8:0] RD   = 9'b010000000;
    localparam logic [8:0] RDLA = 9'b010001000;
    localparam logic [8:0] HI   = 9'b000110000;
    localparam logic [8:0] HLTD = 9'b000100000;
    localparam logic [8:0] LPC  = 9'b000000100;
    localparam logic [8:0] DE   = 9'b000000001;
    localparam logic [8:0] WRDE = 9'b000000011;

    localparam logic [3:0] HLT = 4'd0;
    localparam logic [3:0] SKZ = 4'd1;
    localparam logic [3:0] ADD = 4'd2;
    localparam logic [3:0] LDA = 4'd5;
    localparam logic [3:0] STO = 4'd6;
    localparam logic [3:0] JMP = 4'd7;
    localparam logic [3:0] NOP = 4'd10;

    typedef logic [8:0] tbl_t [8];

    tbl_t t_add  = '{SEL, SR, SRL, SRL, INC, RD, RD, RDLA};
    tbl_t t_skz1 = '{SEL, SR, SRL, SRL, INC, Z, INC, Z};
    tbl_t t_skz0 = '{SEL, SR, SRL, SRL, INC, Z, Z, Z};
    tbl_t t_jmp  = '{SEL, SR, SRL, SRL, INC, Z, LPC, LPC};
    tbl_t t_sto  = '{SEL, SR, SRL, SRL, INC, Z, DE, WRDE};
    tbl_t t_hlt  = '{SEL, SR, SRL, SRL, HI, Z, Z, Z};

    typedef struct {
        logic [2:0] ph;
        logic [8:0] st;
        logic       err;
        int         id;
    } exp_t;

    exp_t sb [$];
    int   issued;
    int   vectors;
    int   miscompares;

    // Drive one cycle of inputs just after the edge and queue what must be seen in that cycle.
    task automatic step(input logic en, input logic mr, input logic res, input logic rs,
                        input logic [3:0] op, input logic z,
                        input logic [2:0] ph, input logic [8:0] st, input logic err);
        exp_t e;
        @(posedge clk);
        #1;
        bus.enable    = en;
        bus.mem_ready = mr;
        bus.resume    = res;
        bus.opcode    = op;
        bus.zero      = z;
        rst           = rs;
        e.ph  = ph;
        e.st  = st;
        e.err = err;
        e.id  = issued;
        sb.push_back(e);
        issued++;
    endtask

    // One zero-wait instruction starting from a visible phase 0.
    task automatic run8(input logic [3:0] op, input logic z, input tbl_t tbl);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, op, z, 3'(i % 8), tbl[i % 8], 1'b0);
        end
    endtask

    // Monitor: compare the DUT against the oldest expectation on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [8:0] act;
            e   = sb.pop_front();
            act = {bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc,
                   bus.ld_ac, bus.ld_pc, bus.wr, bus.data_e};
            vectors++;
            if ((bus.phase !== e.ph) || (act !== e.st) || (bus.bus_err !== e.err)) begin
                miscompares++;
                $display("FAIL vec%0d: got phase=%0d strobes=%b bus_err=%b, expected phase=%0d strobes=%b bus_err=%b",
                         e.id, bus.phase, act, bus.bus_err, e.ph, e.st, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        issued        = 0;
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.mem_ready = 1'b1;
        bus.resume    = 1'b0;
        bus.opcode    = ADD;
        bus.zero      = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then first ADD instruction in 8 cycles
        step(1'b0, 1'b1, 1'b0, 1'b1, ADD, 1'b0, 3'd0, SEL, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, ADD, 1'b0, 3'd0, SEL, 1'b0);
        run8(ADD, 1'b0, t_add);
        run8(SKZ, 1'b1, t_skz1);
        run8(SKZ, 1'b0, t_skz0);
        run8(JMP, 1'b0, t_jmp);
        run8(NOP, 1'b0, t_skz0);

        // LDA with three wait states at phase 5: 11-cycle instruction, no error
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, LDA, 1'b0, 3'(i), t_add[i], 1'b0);
        end
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, LDA, 1'b0, 3'd5, RD, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, LDA, 1'b0, 3'd5, RD, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, LDA, 1'b0, 3'd6, RD, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, LDA, 1'b0, 3'd7, RDLA, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, LDA, 1'b0, 3'd0, SEL, 1'b0);

        // STO with enable toggling: each phase visible for two cycles
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, STO, 1'b0, 3'(i % 8), t_sto[i % 8], 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0, STO, 1'b0, 3'(i % 8), t_sto[i % 8], 1'b0);
        end

        // HLT: one phase-4 cycle with halt+inc_pc, then held halted until resume
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, HLT, 1'b0, 3'(i), t_hlt[i], 1'b0);
        end
        repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, HLT, 1'b0, 3'd4, HLTD, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, HLT, 1'b0, 3'd4, HLTD, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, HLT, 1'b0, 3'd5, Z, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, HLT, 1'b0, 3'd6, Z, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, HLT, 1'b0, 3'd7, Z, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, HLT, 1'b0, 3'd0, SEL, 1'b0);

        // Watchdog: four stalls at phase 1 trip bus_err, resume ignored, reset beats resume
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, ADD, 1'b0, 3'd1, SR, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, ADD, 1'b0, 3'd1, HLTD, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, ADD, 1'b0, 3'd1, HLTD, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, ADD, 1'b0, 3'd1, HLTD, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, ADD, 1'b0, 3'd0, SEL, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, ADD, 1'b0, 3'd1, SR, 1'b0);

        for (int k = 0; (k < 5) && (sb.size() > 0); k++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
